// File: rtl/pcm_pkg.sv
// Shared widths, FSM state encoding and frame packing for the PCM capture path.
package pcm_pkg;

    localparam int unsigned SAMPLE_W = 32'd16;
    localparam int unsigned FRAME_W  = SAMPLE_W + SAMPLE_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } pcm_state_e;

    // Left sample sits in the upper half; in mono the left sample replaces the right one.
    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic [SAMPLE_W-1:0] left,
        input logic [SAMPLE_W-1:0] right,
        input logic                mono
    );
        logic [SAMPLE_W-1:0] right_sel;
        if (mono) begin
            right_sel = left;
        end else begin
            right_sel = right;
        end
        return {left, right_sel};
    endfunction

endpackage

// File: rtl/pcm_frame_fifo.sv
// Show-ahead stereo frame FIFO; exposes both the head frame and the one behind it
// so the owner can preload its output register across a pop.
module pcm_frame_fifo
    import pcm_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 32'd4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [FRAME_W-1:0] wdata,
    output logic [FRAME_W-1:0] head,
    output logic [FRAME_W-1:0] head_next,
    output logic               full,
    output logic               empty,
    output logic               last
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [FRAME_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW:0]        wr_ptr_r;
    logic [AW:0]        rd_ptr_r;
    logic [AW:0]        rd_ptr_inc_s;
    logic [AW:0]        level_s;
    logic               do_push_s;
    logic               do_pop_s;

    // The extra pointer MSB separates a full FIFO from an empty one.
    assign rd_ptr_inc_s = rd_ptr_r + PTR_ONE;
    assign level_s      = wr_ptr_r - rd_ptr_r;
    assign empty        = (wr_ptr_r == rd_ptr_r);
    assign full         = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                          (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign last         = (level_s == PTR_ONE);
    assign do_pop_s     = pop && !empty;
    assign do_push_s    = push && (!full || do_pop_s);
    assign head         = mem_r[rd_ptr_r[AW-1:0]];
    assign head_next    = mem_r[rd_ptr_inc_s[AW-1:0]];

    // Read and write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
        end
    end

    // Frame storage; a push into a full FIFO overwrites the slot being popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 32'd0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/pcm_capture_ctrl.sv
// PCM1801 capture controller: powers the ADC, discards settling frames, buffers
// captured frames for a ready/valid consumer and drains on disable.
module pcm_capture_ctrl
    import pcm_pkg::*;
#(
    parameter int unsigned SETTLE_FRAMES = 32'd16,
    parameter int unsigned FIFO_DEPTH    = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        mono,
    input  logic        smp_valid,
    input  logic [15:0] smp_left,
    input  logic [15:0] smp_right,
    output logic        adc_pdn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_left,
    output logic [15:0] out_right,
    output logic        overrun,
    output logic        busy
);

    localparam int unsigned      CNT_W    = $clog2(SETTLE_FRAMES + 32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_FRAMES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    pcm_state_e         state_r;
    pcm_state_e         state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               cnt_clr_s;
    logic               cnt_inc_s;
    logic               ovr_clr_s;
    logic               pop_s;
    logic               push_s;
    logic               drop_s;
    logic               valid_nxt_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               fifo_last_s;
    logic [FRAME_W-1:0] head_s;
    logic [FRAME_W-1:0] head_next_s;
    logic [FRAME_W-1:0] frame_nxt_s;
    logic               out_valid_r;
    logic [15:0]        out_left_r;
    logic [15:0]        out_right_r;
    logic               adc_pdn_r;
    logic               busy_r;
    logic               overrun_r;

    pcm_frame_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .wdata     (pack_frame(smp_left, smp_right, mono)),
        .head      (head_s),
        .head_next (head_next_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .last      (fifo_last_s)
    );

    // A full FIFO still accepts a frame when its head leaves in the same cycle.
    assign pop_s       = out_valid_r && out_ready;
    assign push_s      = (state_r == ST_RUN) && smp_valid && (!fifo_full_s || pop_s);
    assign drop_s      = (state_r == ST_RUN) && smp_valid && fifo_full_s && !pop_s;
    assign valid_nxt_s = !fifo_empty_s && !(pop_s && fifo_last_s);
    assign frame_nxt_s = pop_s ? head_next_s : head_s;

    // Next-state decode and settle/overrun control strobes.
    always_comb begin
        state_nxt_s = state_r;
        cnt_clr_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        ovr_clr_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s = ST_SETTLE;
                    cnt_clr_s   = 1'b1;
                    ovr_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!enable) begin
                    state_nxt_s = ST_IDLE;
                end else if (smp_valid) begin
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (cnt_clr_s) begin
                cnt_r <= '0;
            end else if (cnt_inc_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    // Status outputs track the state being entered so they change with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_pdn_r <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            adc_pdn_r <= (state_nxt_s == ST_SETTLE) || (state_nxt_s == ST_RUN);
            busy_r    <= (state_nxt_s != ST_IDLE);
            if (ovr_clr_s) begin
                overrun_r <= 1'b0;
            end else if (drop_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    // Registered output stage: a new frame shows one cycle after it lands in the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_left_r  <= 16'h0000;
            out_right_r <= 16'h0000;
        end else begin
            out_valid_r <= valid_nxt_s;
            if (valid_nxt_s) begin
                out_left_r  <= frame_nxt_s[FRAME_W-1:SAMPLE_W];
                out_right_r <= frame_nxt_s[SAMPLE_W-1:0];
            end
        end
    end

    assign adc_pdn   = adc_pdn_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;
    assign out_valid = out_valid_r;
    assign out_left  = out_left_r;
    assign out_right = out_right_r;

endmodule

// File: tb/tb_pcm_capture_ctrl.sv
// Directed-plus-random bench for pcm_capture_ctrl against a queue-based reference model.
`timescale 1ns/1ps
module tb_pcm_capture_ctrl;

    localparam int SETTLE = 16;
    localparam int DEPTH  = 4;
    localparam int M_IDLE = 0, M_SETTLE = 1, M_RUN = 2, M_DRAIN = 3;

    logic        clk = 1'b0;
    logic        rst_n, enable, mono, smp_valid, out_ready;
    logic [15:0] smp_left, smp_right, out_left, out_right;
    logic        adc_pdn, out_valid, overrun, busy;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_out    = 0;
    int          base;
    logic [31:0] exp_q[$];
    logic [31:0] popped_q[$];
    int          m_mode;
    int          m_cnt;
    logic        m_ovr;

    pcm_capture_ctrl #(.SETTLE_FRAMES(SETTLE), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mono      (mono),
        .smp_valid (smp_valid),
        .smp_left  (smp_left),
        .smp_right (smp_right),
        .adc_pdn   (adc_pdn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_left  (out_left),
        .out_right (out_right),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: model the edge from the rules, advance, then compare status outputs.
    task automatic cycle();
        logic        popped;
        int          sz;
        logic [31:0] exp_f;
        logic [31:0] frame_in;
        popped   = out_valid && out_ready;
        sz       = exp_q.size();
        frame_in = {smp_left, (mono ? smp_left : smp_right)};
        if (popped) begin
            if (sz == 0) begin
                check("pop_without_frame", 32'(out_valid), 32'd0);
            end else begin
                exp_f = exp_q.pop_front();
                check("pop_frame", {out_left, out_right}, exp_f);
                popped_q.push_back({out_left, out_right});
                n_out++;
            end
        end
        case (m_mode)
            M_IDLE: if (enable) begin m_mode = M_SETTLE; m_cnt = 0; m_ovr = 1'b0; end
            M_SETTLE: begin
                if (!enable) m_mode = M_IDLE;
                else if (smp_valid) begin
                    m_cnt++;
                    if (m_cnt == SETTLE) m_mode = M_RUN;
                end
            end
            M_RUN: begin
                if (smp_valid) begin
                    if (sz < DEPTH || popped) exp_q.push_back(frame_in);
                    else m_ovr = 1'b1;
                end
                if (!enable) m_mode = M_DRAIN;
            end
            M_DRAIN: if (sz == 0) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
        endcase
        @(posedge clk);
        #1;
        check("adc_pdn", 32'(adc_pdn), 32'(m_mode == M_SETTLE || m_mode == M_RUN));
        check("busy", 32'(busy), 32'(m_mode != M_IDLE));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        smp_left  = l;
        smp_right = r;
        smp_valid = 1'b1;
        cycle();
        smp_valid = 1'b0;
        repeat ($urandom_range(1, 2)) cycle();
    endtask

    task automatic wait_empty(input string tag);
        int budget;
        budget = 60;
        while ((exp_q.size() != 0 || out_valid) && budget > 0) begin
            cycle();
            budget--;
        end
        check(tag, 32'(exp_q.size()) + 32'(out_valid), 32'd0);
    endtask

    task automatic to_run();
        enable = 1'b1;
        cycle();
        for (int k = 0; k < SETTLE; k++) send(16'($urandom), 16'($urandom));
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; mono = 1'b0; smp_valid = 1'b0; out_ready = 1'b0;
        smp_left = 16'h0000; smp_right = 16'h0000;
        m_mode = M_IDLE; m_cnt = 0; m_ovr = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", {out_left, out_right}, 32'h0);
        check("rst_adc_pdn", 32'(adc_pdn), 32'd0);
        check("rst_busy_ovr", {30'd0, busy, overrun}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle();

        // 16 settle frames are discarded, the last four reach the consumer
        out_ready = 1'b1;
        enable    = 1'b1;
        popped_q.delete();
        base = n_out;
        cycle();
        for (int i = 0; i < 20; i++) send(16'(16'h1000 + i), 16'(16'h2000 + i));
        wait_empty("s1_drain");
        check("s1_count", 32'(n_out - base), 32'd4);
        check("s1_first", popped_q[0], 32'h1010_2010);

        // Latency from an empty FIFO
        out_ready = 1'b0;
        smp_left = 16'($urandom); smp_right = 16'($urandom); smp_valid = 1'b1;
        cycle();
        smp_valid = 1'b0;
        check("lat_edge_n", 32'(out_valid), 32'd0);
        cycle();
        check("lat_edge_n1", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        wait_empty("lat_drain");

        // Full FIFO with a frame arriving on the same cycle as a pop
        out_ready = 1'b0;
        base = n_out;
        for (int i = 0; i < DEPTH; i++) send(16'($urandom), 16'($urandom));
        check("full_valid", 32'(out_valid), 32'd1);
        smp_left = 16'($urandom); smp_right = 16'($urandom);
        smp_valid = 1'b1; out_ready = 1'b1;
        cycle();
        smp_valid = 1'b0;
        check("coinc_overrun", 32'(overrun), 32'd0);
        wait_empty("coinc_drain");
        check("coinc_count", 32'(n_out - base), 32'd5);

        // Mono is captured per frame
        out_ready = 1'b0;
        mono = 1'b1;
        send(16'h1234, 16'hABCD);
        mono = 1'b0;
        cycle();
        check("mono_left", 32'(out_left), 32'h1234);
        check("mono_right", 32'(out_right), 32'h1234);
        out_ready = 1'b1;
        wait_empty("mono_drain");

        // Disable in RUN with three frames queued; DRAIN ignores new frames
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom));
        enable = 1'b0;
        cycle();
        check("drain_adc_pdn", 32'(adc_pdn), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);
        base = n_out;
        send(16'($urandom), 16'($urandom));
        out_ready = 1'b1;
        wait_empty("drain_empty");
        cycle();
        check("drain_count", 32'(n_out - base), 32'd3);
        check("drain_idle", 32'(busy), 32'd0);

        // Abort during settle at count 5
        enable = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) send(16'($urandom), 16'($urandom));
        enable = 1'b0;
        cycle();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_adc_pdn", 32'(adc_pdn), 32'd0);

        // Six frames into a stalled FIFO: first four kept, overrun set
        to_run();
        out_ready = 1'b0;
        base = n_out;
        for (int i = 0; i < 6; i++) send(16'($urandom), 16'($urandom));
        check("ovr_valid", 32'(out_valid), 32'd1);
        check("ovr_flag", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        wait_empty("ovr_drain");
        check("ovr_count", 32'(n_out - base), 32'd4);

        // Reset pulse in RUN with two frames queued
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) send(16'($urandom), 16'($urandom));
        rst_n = 1'b0;
        enable = 1'b0;
        #2;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", {out_left, out_right}, 32'h0);
        check("mid_rst_status", {29'd0, adc_pdn, busy, overrun}, 32'd0);
        exp_q.delete();
        m_mode = M_IDLE; m_ovr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) cycle();
        check("post_rst_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
